// File: rtl/frame_field_accum.sv
// frame_field_accum: buffers packed {a, b} words in a small FIFO, accumulates
// a + b[HALF-1:0] over FRAME words and hands the frame total downstream over a
// valid/ready handshake.
//
// Build option: FRAME_FIELD_ACCUM_SAT_EN
//   defined   - accumulator clamps to 2^W-1 on carry-out, ovf flags the clamp
//   undefined - accumulator wraps modulo 2^W, ovf flags the wrap
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready = FIFO not full)
//   in_data  [W]       packed word {a[N], b[M]}
//   out_valid/out_ready downstream handshake for the frame total
//   out_sum  [W]       frame total
//   out_ovf            frame total exceeded 2^W-1
//   fifo_level [LW]    current FIFO occupancy
module frame_field_accum #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 8,
  parameter int unsigned FRAME = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N+M-1:0]               in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N+M-1:0]               out_sum,
  output logic                         out_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned W    = N + M;
  localparam int unsigned HALF = M / 2;
  localparam int unsigned CW   = $clog2(FRAME + 1);
  localparam int unsigned LW   = $clog2(DEPTH + 1);
  localparam int unsigned AW   = $clog2(DEPTH);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;

  logic            push_c;
  logic            pop_c;
  logic [W-1:0]    head_c;
  logic [W-1:0]    term_c;
  logic [W:0]      sum_c;
  logic            unused_bits_c;

  // FIFO storage: no reset needed, validity is tracked by the pointers/level
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Full is judged on the registered level only, so a same-cycle pop never opens a slot
  assign in_ready = (level_q != LW'(DEPTH));
  assign push_c   = in_valid && in_ready;

  // Per-word term from the FIFO head; b's upper half is deliberately dropped
  assign head_c        = mem_q[rd_ptr_q];
  assign term_c        = W'(head_c[W-1:M]) + W'(head_c[HALF-1:0]);
  assign sum_c         = (W+1)'(acc_q) + (W+1)'(term_c);
  assign unused_bits_c = ^head_c[M-1:HALF];

  // FSM state and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: pop/accumulate in ACC, present the total in OUT
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pop_c   = 1'b0;
    unique case (state_q)
      S_ACC: begin
        if (level_q != '0) begin
          pop_c = 1'b1;
          cnt_d = cnt_q + CW'(1);
`ifdef FRAME_FIELD_ACCUM_SAT_EN
          acc_d = sum_c[W] ? {W{1'b1}} : sum_c[W-1:0];
`else
          acc_d = sum_c[W-1:0];
`endif
          if (sum_c[W]) ovf_d = 1'b1;
          if (cnt_d == CW'(FRAME)) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  assign out_valid  = (state_q == S_OUT);
  assign out_sum    = acc_q;
  assign out_ovf    = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_frame_field_accum.sv
module tb_frame_field_accum;

  localparam int unsigned W  = 12;
  localparam int unsigned LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [W-1:0]  in_data, out_sum;
  logic [LW-1:0] fifo_level;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [W-1:0]  b_in_data, b_out_sum;
  logic [LW-1:0] b_fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  frame_field_accum #(.N(4), .M(8), .FRAME(4), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .fifo_level(fifo_level)
  );

  frame_field_accum #(.N(4), .M(8), .FRAME(200), .DEPTH(4)) u_dut_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_ovf(b_out_ovf), .fifo_level(b_fifo_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [W-1:0] d, input int n);
    in_data  = d;
    in_valid = 1'b1;
    repeat (n) step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int maxc, output bit ok);
    int i;
    i = 0;
    while (!out_valid && i < maxc) begin
      step();
      i++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'($urandom);
    in_data     = W'($urandom);
    out_ready   = 1'($urandom);
    b_in_valid  = 1'($urandom);
    b_in_data   = W'($urandom);
    b_out_ready = 1'($urandom);
    repeat (3) step();
    in_valid    = 1'b0;
    b_in_valid  = 1'b0;
    out_ready   = 1'b1;
    b_out_ready = 1'b1;
    rst_n       = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 12'h000) begin n_err++; $display("FAIL reset_out_sum: got %h want 000", out_sum); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_big_out_valid: got %b want 0", b_out_valid); end
    n_cmp++; if (b_fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_big_fifo_level: got %0d want 0", b_fifo_level); end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    push_n(12'hFFF, 4);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_sum !== 12'h078) begin n_err++; $display("FAIL single_sum: got %h want 078", out_sum); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", out_ovf); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_out_one_cycle: got %b want 0", out_valid); end
    n_cmp++; if (out_sum !== 12'h000) begin n_err++; $display("FAIL single_acc_cleared: got %h want 000", out_sum); end
  endtask

  task automatic test_ignored_bits();
    bit ok;
    out_ready = 1'b1;
    push_n(12'h3F0, 4);
    wait_out(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ignored_timeout: got %b want 1", ok); end
    n_cmp++; if (out_sum !== 12'h00C) begin n_err++; $display("FAIL ignored_sum: got %h want 00c", out_sum); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL ignored_ovf: got %b want 0", out_ovf); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [8];
    logic [W-1:0] res [$];
    logic [W-1:0] got;
    int idx, cyc;
    bit acc;
    words = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h105, 12'h106, 12'h107, 12'h108};
    out_ready = 1'b1;
    idx = 0;
    cyc = 0;
    while ((idx < 8 || res.size() < 2) && cyc < 100) begin
      in_valid = (idx < 8);
      in_data  = (idx < 8) ? words[idx] : 12'h000;
      acc      = in_valid && in_ready;
      step();
      if (acc) idx++;
      if (out_valid) res.push_back(out_sum);
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (res.size() !== 2) begin n_err++; $display("FAIL b2b_frames: got %0d want 2", res.size()); end
    got = (res.size() > 0) ? res[0] : 12'hxxx;
    n_cmp++; if (got !== 12'h00A) begin n_err++; $display("FAIL b2b_sum0: got %h want 00a", got); end
    got = (res.size() > 1) ? res[1] : 12'hxxx;
    n_cmp++; if (got !== 12'h01E) begin n_err++; $display("FAIL b2b_sum1: got %h want 01e", got); end
    step();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words [8];
    int idx, cyc;
    bit acc, ok;
    words = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h105, 12'h106, 12'h107, 12'h108};
    out_ready = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      acc      = in_ready;
      step();
      if (acc) idx++;
      cyc++;
    end
    n_cmp++; if (idx !== 8) begin n_err++; $display("FAIL bp_accepted: got %0d want 8", idx); end
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL bp_level[%0d]: got %0d want 4", i, fifo_level); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_sum !== 12'h00A) begin n_err++; $display("FAIL bp_sum_stable[%0d]: got %h want 00a", i, out_sum); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_handshake: got %b want 0", out_valid); end
    wait_out(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got %b want 1", ok); end
    n_cmp++; if (out_sum !== 12'h01E) begin n_err++; $display("FAIL bp_sum2: got %h want 01e", out_sum); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf: got %b want 0", out_ovf); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL bp_drained: got %0d want 0", fifo_level); end
    step();
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_sum;
    int accepted, cyc;
    bit acc;
`ifdef FRAME_FIELD_ACCUM_SAT_EN
    exp_sum = 12'hFFF;
`else
    exp_sum = 12'h770;
`endif
    b_out_ready = 1'b1;
    b_in_data   = 12'hFFF;
    accepted    = 0;
    cyc         = 0;
    while (!b_out_valid && cyc < 1000) begin
      b_in_valid = (accepted < 200);
      acc        = b_in_valid && b_in_ready;
      step();
      if (acc) accepted++;
      cyc++;
    end
    b_in_valid = 1'b0;
    n_cmp++; if (b_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_timeout: got %b want 1", b_out_valid); end
    n_cmp++; if (accepted !== 200) begin n_err++; $display("FAIL ovf_accepted: got %0d want 200", accepted); end
    n_cmp++; if (b_out_sum !== exp_sum) begin n_err++; $display("FAIL ovf_sum: got %h want %h", b_out_sum, exp_sum); end
    n_cmp++; if (b_out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", b_out_ovf); end
    step();
    n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_out_one_cycle: got %b want 0", b_out_valid); end
    n_cmp++; if (b_out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_flag_cleared: got %b want 0", b_out_ovf); end
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    out_ready = 1'b1;
    push_n(12'hFFF, 2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (out_sum !== 12'h000) begin n_err++; $display("FAIL midrst_acc: got %h want 000", out_sum); end
    step();
    rst_n = 1'b1;
    step();
    push_n(12'h001, 4);
    wait_out(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL midrst_timeout: got %b want 1", ok); end
    n_cmp++; if (out_sum !== 12'h004) begin n_err++; $display("FAIL midrst_sum: got %h want 004", out_sum); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", out_ovf); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignored_bits();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_mid_frame_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
